// File: rtl/gemm_tile_sequencer_pkg.sv
// gemm_tile_sequencer_pkg: gemm register map, default tile sizes, dim word layout and FSM states
package gemm_tile_sequencer_pkg;
  localparam logic [31:0] BASE_ADDR = 32'h9000_0000;
  localparam int SUPER_SYS_ROWS = 4;
  localparam int SUPER_SYS_COLS = 4;
  localparam logic [31:0] REG_A = 32'd0;
  localparam logic [31:0] REG_B = 32'd4;
  localparam logic [31:0] REG_C = 32'd8;
  localparam logic [31:0] REG_ASTRIDE = 32'd12;
  localparam logic [31:0] REG_BSTRIDE = 32'd16;
  localparam logic [31:0] REG_CTRL = 32'd20;
  localparam logic [31:0] REG_DIM = 32'd24;
  typedef struct packed {
    logic [4:0] nsize;
    logic [4:0] ksize;
    logic [4:0] msize;
  } dim_t;
  typedef enum logic [3:0] {
    IDLE, CALC, CFG, FULL_REQ, FULL_WAIT, ADVANCE, DONE_REQ, DONE_WAIT, FINISH
  } state_t;
  // DIM goes last: writing it is what launches the tile on the gemm side
  function automatic logic [31:0] cfg_offset(input logic [2:0] idx);
    return idx == 3'd0 ? REG_ASTRIDE :
           idx == 3'd1 ? REG_BSTRIDE :
           idx == 3'd2 ? REG_A :
           idx == 3'd3 ? REG_B :
           idx == 3'd4 ? REG_C :
           idx == 3'd5 ? REG_CTRL : REG_DIM;
  endfunction
endpackage

// File: rtl/gemm_tile_sequencer_tile_loop_counter.sv
// gemm_tile_sequencer_tile_loop_counter: n/m/k tile indices, clipped tile sizes and loop-nest advance
module gemm_tile_sequencer_tile_loop_counter #(
  parameter int DIM_W = 16,
  parameter int BLK_M = 16,
  parameter int BLK_N = 4,
  parameter int BLK_K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_n,
  input  logic [DIM_W-1:0] dim_k,
  output logic [DIM_W-1:0] m_q,
  output logic [DIM_W-1:0] n_q,
  output logic [DIM_W-1:0] k_q,
  output logic [DIM_W-1:0] msize,
  output logic [DIM_W-1:0] nsize,
  output logic [DIM_W-1:0] ksize,
  output logic             first,
  output logic             last,
  output logic             last_tile
);
  localparam logic [DIM_W:0] BM = (DIM_W+1)'(BLK_M);
  localparam logic [DIM_W:0] BN = (DIM_W+1)'(BLK_N);
  localparam logic [DIM_W:0] BK = (DIM_W+1)'(BLK_K);
  logic [DIM_W-1:0] m_d, n_d, k_d, m_rem, n_rem, k_rem;
  logic [DIM_W:0] m_nx, n_nx, k_nx;
  logic m_ovf, n_ovf, k_ovf;
  // one extra bit on the next-index sums so overflow near 2**DIM_W is still seen
  always_comb begin
    m_rem = dim_m - m_q;
    n_rem = dim_n - n_q;
    k_rem = dim_k - k_q;
    msize = {1'b0, m_rem} < BM ? m_rem : BM[DIM_W-1:0];
    nsize = {1'b0, n_rem} < BN ? n_rem : BN[DIM_W-1:0];
    ksize = {1'b0, k_rem} < BK ? k_rem : BK[DIM_W-1:0];
    m_nx = {1'b0, m_q} + BM;
    n_nx = {1'b0, n_q} + BN;
    k_nx = {1'b0, k_q} + BK;
    m_ovf = m_nx >= {1'b0, dim_m};
    n_ovf = n_nx >= {1'b0, dim_n};
    k_ovf = k_nx >= {1'b0, dim_k};
    first = k_q == '0;
    last = k_ovf;
    last_tile = k_ovf & m_ovf & n_ovf;
    k_d = load ? '0 : advance ? (k_ovf ? '0 : k_nx[DIM_W-1:0]) : k_q;
    m_d = load ? '0 : advance & k_ovf ? (m_ovf ? '0 : m_nx[DIM_W-1:0]) : m_q;
    n_d = load ? '0 : advance & k_ovf & m_ovf ? (n_ovf ? '0 : n_nx[DIM_W-1:0]) : n_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: bus initiator that tiles a whole GEMM command into gemm register writes and polls
module gemm_tile_sequencer #(
  parameter logic [31:0] BASE_ADDR = gemm_tile_sequencer_pkg::BASE_ADDR,
  parameter int BLK_M = 16,
  parameter int BLK_N = gemm_tile_sequencer_pkg::SUPER_SYS_ROWS,
  parameter int BLK_K = gemm_tile_sequencer_pkg::SUPER_SYS_COLS,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cmd_m,
  input  logic [DIM_W-1:0] cmd_n,
  input  logic [DIM_W-1:0] cmd_k,
  input  logic [31:0]      cmd_a_addr,
  input  logic [31:0]      cmd_b_addr,
  input  logic [31:0]      cmd_c_addr,
  output logic             busy,
  output logic             done,
  output logic             system_bus_en,
  output logic             system_bus_rdwr,
  output logic [31:0]      system_bus_addr,
  output logic [31:0]      system_bus_wr_data,
  input  logic [31:0]      system_bus_rd_data
);
  import gemm_tile_sequencer_pkg::*;
  state_t state_q, state_d;
  logic [2:0] cfg_q, cfg_d;
  logic [DIM_W-1:0] dm_q, dm_d, dn_q, dn_d, dk_q, dk_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0] at_q, at_d, bt_q, bt_d, ct_q, ct_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0] ctrl_q, ctrl_d;
  dim_t dim_q, dim_d;
  logic load, advance, first, last, last_tile;
  logic [DIM_W-1:0] m_idx, n_idx, k_idx, msize, nsize, ksize;
  logic [6:0][31:0] cfg_data;
  logic unused_bits;
  gemm_tile_sequencer_tile_loop_counter #(
    .DIM_W(DIM_W), .BLK_M(BLK_M), .BLK_N(BLK_N), .BLK_K(BLK_K)
  ) u_tile_loop_counter (
    .clk(clk), .rst(rst), .load(load), .advance(advance),
    .dim_m(dm_q), .dim_n(dn_q), .dim_k(dk_q),
    .m_q(m_idx), .n_q(n_idx), .k_q(k_idx),
    .msize(msize), .nsize(nsize), .ksize(ksize),
    .first(first), .last(last), .last_tile(last_tile)
  );
  assign unused_bits = ^{system_bus_rd_data[31:1], msize, nsize, ksize};
  assign cfg_data = {{17'd0, dim_q}, {30'd0, ctrl_q}, ct_q, bt_q, at_q, 32'(dn_q), 32'(dk_q)};
  assign busy = state_q != IDLE && state_q != FINISH;
  assign done = state_q == FINISH;
  assign system_bus_addr = addr_d;
  assign system_bus_wr_data = wdata_d;
  always_comb begin
    state_d = state_q;
    cfg_d = cfg_q;
    dm_d = dm_q;
    dn_d = dn_q;
    dk_d = dk_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    system_bus_en = 1'b0;
    system_bus_rdwr = 1'b0;
    load = 1'b0;
    advance = 1'b0;
    at_d = state_q == CALC ? a_q + 32'(k_idx) + 32'(m_idx) * 32'(dk_q) : at_q;
    bt_d = state_q == CALC ? b_q + 32'(n_idx) + (32'(k_idx) + 32'(ksize) - 32'd1) * 32'(dn_q) : bt_q;
    ct_d = state_q == CALC ? c_q + 32'(n_idx) + 32'(m_idx) * 32'(dn_q) : ct_q;
    ctrl_d = state_q == CALC ? {first, last} : ctrl_q;
    dim_d = state_q == CALC ? '{nsize: nsize[4:0], ksize: ksize[4:0], msize: msize[4:0]} : dim_q;
    case (state_q)
      IDLE: if (start) begin
        load = 1'b1;
        dm_d = cmd_m;
        dn_d = cmd_n;
        dk_d = cmd_k;
        a_d = cmd_a_addr;
        b_d = cmd_b_addr;
        c_d = cmd_c_addr;
        state_d = (cmd_m == '0 || cmd_n == '0 || cmd_k == '0) ? FINISH : CALC;
      end
      CALC: begin
        cfg_d = '0;
        state_d = CFG;
      end
      CFG: begin
        system_bus_en = 1'b1;
        system_bus_rdwr = 1'b1;
        addr_d = BASE_ADDR + cfg_offset(cfg_q);
        wdata_d = cfg_data[cfg_q];
        cfg_d = cfg_q + 3'd1;
        state_d = cfg_q == 3'd6 ? FULL_REQ : CFG;
      end
      FULL_REQ: begin
        system_bus_en = 1'b1;
        addr_d = BASE_ADDR + REG_A;
        state_d = FULL_WAIT;
      end
      FULL_WAIT: state_d = system_bus_rd_data[0] ? FULL_REQ : ADVANCE;
      ADVANCE: begin
        advance = 1'b1;
        state_d = last_tile ? DONE_REQ : CALC;
      end
      DONE_REQ: begin
        system_bus_en = 1'b1;
        addr_d = BASE_ADDR + REG_DIM;
        state_d = DONE_WAIT;
      end
      DONE_WAIT: state_d = system_bus_rd_data[0] ? FINISH : DONE_REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q <= '0;
      dm_q <= '0;
      dn_q <= '0;
      dk_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      at_q <= '0;
      bt_q <= '0;
      ct_q <= '0;
      ctrl_q <= '0;
      dim_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      dm_q <= dm_d;
      dn_q <= dn_d;
      dk_q <= dk_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      at_q <= at_d;
      bt_q <= bt_d;
      ct_q <= ct_d;
      ctrl_q <= ctrl_d;
      dim_q <= dim_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: command table with a write scoreboard, plus FULL back-pressure, reset and busy-start sequences
module tb_gemm_tile_sequencer;
  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int BM = 16, BN = 4, BK = 4;
  typedef struct {
    logic [15:0] m, n, k;
    logic [31:0] a, b, c;
    int full_hold, done_hold, tiles, inject;
  } vec_t;
  typedef struct packed {
    logic [31:0] addr, data;
  } wr_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] cmd_m = '0, cmd_n = '0, cmd_k = '0;
  logic [31:0] cmd_a_addr = '0, cmd_b_addr = '0, cmd_c_addr = '0;
  logic busy, done, en, rdwr;
  logic [31:0] addr, wdata;
  logic [31:0] rd_data = '0;
  int full_hold = 0, done_hold = 0, full_polls = 0, done_polls = 0;
  int n_chk = 0, n_pass = 0;
  wr_t exp_q[$];
  logic [31:0] obs[$];
  vec_t tbl[7];
  gemm_tile_sequencer #(.BLK_M(BM), .BLK_N(BN), .BLK_K(BK)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
    .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
    .busy(busy), .done(done),
    .system_bus_en(en), .system_bus_rdwr(rdwr),
    .system_bus_addr(addr), .system_bus_wr_data(wdata),
    .system_bus_rd_data(rd_data)
  );
  always #5 clk = ~clk;
  // gemm responder: FULL reads 1 for full_hold polls per tile, DONE reads 1 after done_hold polls
  always @(posedge clk) begin
    rd_data <= '0;
    if (en && !rdwr && addr == BASE) begin
      rd_data <= {31'd0, full_polls < full_hold};
      full_polls <= full_polls + 1;
    end
    if (en && !rdwr && addr == BASE + 24) begin
      rd_data <= {31'd0, done_polls >= done_hold};
      done_polls <= done_polls + 1;
    end
    if (en && rdwr && addr == BASE + 24) full_polls <= 0;
    if (start) done_polls <= 0;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask
  task automatic push_wr(input logic [31:0] off, input logic [31:0] data);
    exp_q.push_back('{addr: BASE + off, data: data});
  endtask
  task automatic push_model(input vec_t v);
    for (int n = 0; n < int'(v.n); n += BN)
      for (int m = 0; m < int'(v.m); m += BM)
        for (int k = 0; k < int'(v.k); k += BK) begin
          int ms, ns, ks;
          ms = int'(v.m) - m < BM ? int'(v.m) - m : BM;
          ns = int'(v.n) - n < BN ? int'(v.n) - n : BN;
          ks = int'(v.k) - k < BK ? int'(v.k) - k : BK;
          push_wr(12, 32'(v.k));
          push_wr(16, 32'(v.n));
          push_wr(0, v.a + 32'(k) + 32'(m) * 32'(v.k));
          push_wr(4, v.b + 32'(n) + 32'(k + ks - 1) * 32'(v.n));
          push_wr(8, v.c + 32'(n) + 32'(m) * 32'(v.n));
          push_wr(20, {30'd0, k == 0, k + BK >= int'(v.k)});
          push_wr(24, 32'(ms + ks * 32 + ns * 1024));
        end
  endtask
  task automatic run_cmd(input vec_t v);
    int cyc, en_cnt, dim_cnt, polls_since, busy_bad, b2b, extra, done_cyc, exp_en;
    logic prev_rd;
    wr_t e;
    exp_q.delete();
    obs.delete();
    push_model(v);
    full_hold = v.full_hold;
    done_hold = v.done_hold;
    {cmd_m, cmd_n, cmd_k} = {v.m, v.n, v.k};
    {cmd_a_addr, cmd_b_addr, cmd_c_addr} = {v.a, v.b, v.c};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {en_cnt, dim_cnt, polls_since, busy_bad, b2b, extra} = '0;
    prev_rd = 1'b0;
    done_cyc = -1;
    cyc = 1;
    while (done_cyc < 0 && cyc < 4000) begin
      start = cyc == v.inject;
      if (cyc == v.inject) {cmd_m, cmd_n, cmd_k} = {16'd5, 16'd5, 16'd5};
      if (en) en_cnt++;
      if (en && !rdwr) begin
        if (prev_rd) b2b++;
        if (addr == BASE) polls_since++;
      end
      prev_rd = en && !rdwr;
      if (en && rdwr) begin
        if (addr == BASE + 12 && dim_cnt > 0) check("full_polls_before_next_tile", polls_since, v.full_hold + 1);
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          check("wr_addr", addr, e.addr);
          check("wr_data", wdata, e.data);
        end
        obs.push_back(wdata);
        if (addr == BASE + 24) begin
          dim_cnt++;
          polls_since = 0;
        end
      end
      if (!busy && !done) busy_bad++;
      if (done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done_cyc >= 0, 1);
    check("tile_count", dim_cnt, v.tiles);
    check("writes_missing", exp_q.size(), 0);
    check("writes_extra", extra, 0);
    check("busy_gap", busy_bad, 0);
    check("poll_back_to_back", b2b, 0);
    exp_en = v.tiles == 0 ? 0 : 7 * v.tiles + v.tiles * (v.full_hold + 1) + v.done_hold + 1;
    check("bus_en_cycles", en_cnt, exp_en);
    if (v.tiles == 0) check("zero_size_done_latency", done_cyc, 1);
    check("done_pulse_width", done, 0);
    check("idle_after_done", busy, 0);
  endtask
  initial begin
    tbl[0] = '{16'd1, 16'd1, 16'd1, 32'd0, 32'd10, 32'd20, 0, 0, 1, -1};
    tbl[1] = '{16'd20, 16'd6, 16'd5, 32'd0, 32'd100, 32'd200, 0, 0, 8, -1};
    tbl[2] = '{16'd32, 16'd1, 16'd1, 32'd1000, 32'd2000, 32'd3000, 5, 0, 2, -1};
    tbl[3] = '{16'd3, 16'd0, 16'd2, 32'd0, 32'd0, 32'd0, 0, 0, 0, -1};
    tbl[4] = '{16'd0, 16'd5, 16'd5, 32'd7, 32'd7, 32'd7, 0, 0, 0, -1};
    tbl[5] = '{16'd33, 16'd9, 16'd13, 32'hFFFF_FFF0, 32'h8000_0000, 32'h1234_5678, 1, 2, 36, -1};
    tbl[6] = '{16'd17, 16'd5, 16'd4, 32'd64, 32'd128, 32'd256, 0, 1, 4, 15};
    @(negedge clk);
    check("reset_en", en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", addr, 0);
    check("reset_wdata", wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i]);
      if (i == 0) begin
        check("unit_ctrl", obs[5], 3);
        check("unit_dim", obs[6], 1057);
      end
      if (i == 1) begin
        check("first_a", obs[2], 0);
        check("first_b", obs[3], 118);
        check("first_c", obs[4], 200);
        check("first_ctrl", obs[5], 2);
        check("first_dim", obs[6], 32'h1090);
        check("last_a", obs[51], 84);
        check("last_b", obs[52], 128);
        check("last_c", obs[53], 300);
        check("last_ctrl", obs[54], 1);
        check("last_dim", obs[55], 2084);
      end
    end
    begin
      int dims, done_cnt, en_cnt;
      logic hit;
      full_hold = 0;
      done_hold = 0;
      {cmd_m, cmd_n, cmd_k} = {16'd20, 16'd6, 16'd5};
      {cmd_a_addr, cmd_b_addr, cmd_c_addr} = {32'd0, 32'd100, 32'd200};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      {dims, done_cnt, en_cnt} = '0;
      hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
        if (en && rdwr && dims == 2 && addr == BASE + 4) hit = 1'b1;
        else begin
          if (en && rdwr && addr == BASE + 24) dims++;
          if (done) done_cnt++;
          @(negedge clk);
        end
      end
      check("reached_tile3_cfg", hit, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_en", en, 0);
      check("async_rst_rdwr", rdwr, 0);
      check("async_rst_addr", addr, 0);
      check("async_rst_wdata", wdata, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (en) en_cnt++;
      end
      check("aborted_done_pulses", done_cnt, 0);
      check("aborted_bus_quiet", en_cnt, 0);
    end
    run_cmd(tbl[1]);
    check("restart_first_b", obs[3], 118);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
